// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root datapath: operand width and
// the default depth of its input FIFO.
package sqrt_pkg;
  localparam int SQRT_DW         = 8;
  localparam int SQRT_FIFO_DEPTH = 4;
endpackage

// File: rtl/sqrt_in_fifo.sv
// Input operand FIFO in front of the square-root unit. Registered storage,
// no empty bypass: a pushed operand is offered on the cycle after the push.
module sqrt_in_fifo
  import sqrt_pkg::*;
#(
  parameter int DW    = SQRT_DW,
  parameter int DEPTH = SQRT_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enb_i,
  input  logic [DW-1:0]              in_dt_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       busy_i,
  output logic [DW-1:0]              out_dt_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign full_o      = (cnt_q == CW'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign count_o     = cnt_q;
  // A full FIFO refuses pushes even when the head leaves this cycle.
  assign in_ready_o  = !full_o && enb_i;
  assign out_valid_o = !empty_o && !busy_i && enb_i;
  assign out_dt_o    = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_dt_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: doc/sqrt_in_fifo.md
SQRT_IN_FIFO -- requirements
Module: sqrt_in_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enb_i  input  1  stage enable; low freezes all state.
REQ-006 SHALL have port in_dt_i  input  DW  upstream operand.
REQ-007 SHALL have port in_valid_i  input  1  upstream operand valid.
REQ-008 SHALL have port in_ready_o  output  1  FIFO accepts operand.
REQ-009 SHALL have port busy_i  input  1  downstream square-root unit busy.
REQ-010 SHALL have port out_dt_o  output  DW  head operand to the square-root unit.
REQ-011 SHALL have port out_valid_o  output  1  head operand offered.
REQ-012 SHALL have port out_ready_i  input  1  square-root unit accepts operand.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 SHALL have ports full_o and empty_o  output  1 each  occupancy flags.

Function
REQ-015 Push SHALL occur on a cycle where in_valid_i && in_ready_o; in_dt_i is written at the write pointer.
REQ-016 in_ready_o SHALL equal !full_o && enb_i; no push when full, even if a pop occurs in the same cycle (no bypass).
REQ-017 out_valid_o SHALL equal !empty_o && !busy_i && enb_i.
REQ-018 Pop SHALL occur on a cycle where out_valid_o && out_ready_i; the read pointer advances.
REQ-019 out_dt_o SHALL be the entry at the read pointer, driven from storage; it is undefined-free (last written or reset value) when empty.
REQ-020 Latency: an operand pushed in cycle N SHALL be visible on out_dt_o with out_valid_o high in cycle N+1 at the earliest (no empty bypass).
REQ-021 Pointers SHALL wrap modulo DEPTH; count_o SHALL increment on push-only, decrement on pop-only, and hold on push+pop or neither.
REQ-022 full_o SHALL be (count_o == DEPTH); empty_o SHALL be (count_o == 0).
REQ-023 Operands SHALL leave in strict arrival order; none dropped or duplicated.
REQ-024 With enb_i low: no push, no pop, pointers/count/storage held; outputs other than in_ready_o/out_valid_o hold.
REQ-025 busy_i high SHALL block pop without altering stored data or count.
REQ-026 A source holding in_valid_i while full SHALL be accepted on the first cycle full_o falls.

Reset
REQ-027 rstn_i low SHALL immediately clear pointers, count_o=0, storage=0, giving empty_o=1, full_o=0, out_valid_o=0, out_dt_o=0.
REQ-028 During reset in_ready_o SHALL equal enb_i; first push allowed on the first rising edge after rstn_i deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all stored operands without producing a pop.

Structure
REQ-030 DW and default DEPTH SHALL be localparams in shared package sqrt_pkg, also used by the square-root top.
REQ-031 Storage, pointers and count SHALL be inline; no sub-module.

Verification
REQ-032 Reset then push 0x10,0x51,0xFF with out_ready_i=1, busy_i=0 -> out_dt_o sequence 0x10,0x51,0xFF, each one cycle after push.
REQ-033 Push 4 operands with out_ready_i=0 -> full_o=1, count_o=4, in_ready_o=0; 5th operand 0x22 held upstream and accepted cycle after first pop.
REQ-034 Full FIFO, in_valid_i=1 and pop same cycle -> count_o 3, no push that cycle; push next cycle -> count_o 4.
REQ-035 Non-empty, busy_i=1 for 5 cycles -> out_valid_o=0, count_o unchanged; busy_i=0 -> head 0x10 popped.
REQ-036 enb_i=0 for 3 cycles while in_valid_i=1, out_ready_i=1 -> no count change; resumes on enb_i=1.
REQ-037 Push 6 operands across wrap with interleaved pops, then rstn_i pulse with count_o=2 -> count_o=0, empty_o=1, out_valid_o=0 immediately.
